// File: rtl/video_line_sequencer.sv
// Composite-video raster scanner: 1-bpp BRAM rows -> sync/black/white level + PWM threshold, registered 1 clk after (h,v).
// Free-running, no backpressure; `define VIDEO_TESTPAT_EN adds a test_pat input selecting an 8x8 checkerboard.
module video_line_sequencer #(
  parameter int PIX_W     = 300,
  parameter int PIX_DIV   = 4,
  parameter int H_TOTAL   = 1728,
  parameter int H_SYNC    = 127,
  parameter int H_BACK    = 155,
  parameter int V_TOTAL   = 625,
  parameter int V_SYNC    = 5,
  parameter int V_BACK    = 12,
  parameter int ACT_LINES = 608,
  parameter int LVL_SYNC  = 0,
  parameter int LVL_BLACK = 4,
  parameter int LVL_WHITE = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef VIDEO_TESTPAT_EN
  input  logic             test_pat,
`endif
  output logic [9:0]       rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic [1:0]       level,
  output logic [7:0]       pwm_thresh,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_ACT = H_SYNC + H_BACK;
  localparam int V_ACT = V_SYNC + V_BACK;
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int PW    = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_M1  = HW'(H_ACT - 1);
  localparam logic [HW-1:0] H_BROAD   = HW'(H_TOTAL - H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACT);
  localparam logic [VW-1:0] V_END_C   = VW'(V_ACT + ACT_LINES);
  localparam logic [PW-1:0] P_LAST    = PW'(PIX_W - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(PIX_DIV - 1);

  if (H_ACT + PIX_W * PIX_DIV > H_TOTAL) begin : g_bad_h
    $error("video_line_sequencer: active pixels overrun H_TOTAL");
  end
  if (V_ACT + ACT_LINES > V_TOTAL) begin : g_bad_v
    $error("video_line_sequencer: active lines overrun V_TOTAL");
  end
  if (ACT_LINES > 1024) begin : g_bad_rows
    $error("video_line_sequencer: ACT_LINES exceeds 10-bit row address");
  end

  typedef enum logic [1:0] {
    LV_SYNC  = 2'd0,
    LV_BLACK = 2'd1,
    LV_WHITE = 2'd2
  } level_e;

  logic [HW-1:0]    h_cnt_q, h_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [DW-1:0]    div_q, div_d;
  logic             pix_on_q, pix_on_d;
  logic [PIX_W-1:0] row_q, row_d;
  logic [9:0]       rd_addr_q, rd_addr_d;
  level_e           level_q, level_d;
  logic [7:0]       pwm_q, pwm_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
`ifdef VIDEO_TESTPAT_EN
  logic             tp_q, tp_d;
`endif

  logic             vsync_line;
  logic             act_line;
  logic [VW-1:0]    row_idx;
  logic             pix_bit;

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pix_d     = pix_q;
    div_d     = div_q;
    pix_on_d  = pix_on_q;
    row_d     = row_q;
    rd_addr_d = rd_addr_q;
    level_d   = LV_BLACK;
    line_d    = 1'b0;
    frame_d   = 1'b0;
    pwm_d     = 8'(LVL_BLACK);

    vsync_line = (v_cnt_q < V_SYNC_C);
    act_line   = (v_cnt_q >= V_ACT_C) && (v_cnt_q < V_END_C);
    row_idx    = v_cnt_q - V_ACT_C;

`ifdef VIDEO_TESTPAT_EN
    // Latched once per line so a mid-line toggle cannot tear the picture.
    tp_d = tp_q;
    if (h_cnt_q == '0) tp_d = test_pat;
    pix_bit = tp_q ? (pix_q[3] ^ row_idx[3]) : row_q[pix_q];
`else
    pix_bit = row_q[pix_q];
`endif

    if (!en) begin
      h_cnt_d  = '0;
      v_cnt_d  = '0;
      pix_d    = '0;
      div_d    = '0;
      pix_on_d = 1'b0;
    end else begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end

      // pix_q/div_q track the pixel under h_cnt_q; armed one clock before H_ACT.
      if (h_cnt_q == H_ACT_M1) begin
        pix_d    = '0;
        div_d    = '0;
        pix_on_d = 1'b1;
      end else if (pix_on_q) begin
        if (div_q == D_LAST) begin
          div_d = '0;
          if (pix_q == P_LAST) pix_on_d = 1'b0;
          else                 pix_d    = pix_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      if (act_line && (h_cnt_q == '0))      rd_addr_d = 10'(row_idx);
      if (act_line && (h_cnt_q == H_SYNC_C)) row_d     = rd_data;

      if (vsync_line)                level_d = (h_cnt_q < H_BROAD) ? LV_SYNC : LV_BLACK;
      else if (h_cnt_q < H_SYNC_C)   level_d = LV_SYNC;
      else if (act_line && pix_on_q) level_d = pix_bit ? LV_WHITE : LV_BLACK;
      else                           level_d = LV_BLACK;

      line_d  = (h_cnt_q == '0);
      frame_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    case (level_d)
      LV_SYNC:  pwm_d = 8'(LVL_SYNC);
      LV_WHITE: pwm_d = 8'(LVL_WHITE);
      default:  pwm_d = 8'(LVL_BLACK);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pix_q     <= '0;
      div_q     <= '0;
      pix_on_q  <= 1'b0;
      row_q     <= '0;
      rd_addr_q <= '0;
      level_q   <= LV_BLACK;
      pwm_q     <= 8'(LVL_BLACK);
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
`ifdef VIDEO_TESTPAT_EN
      tp_q      <= 1'b0;
`endif
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pix_q     <= pix_d;
      div_q     <= div_d;
      pix_on_q  <= pix_on_d;
      row_q     <= row_d;
      rd_addr_q <= rd_addr_d;
      level_q   <= level_d;
      pwm_q     <= pwm_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
`ifdef VIDEO_TESTPAT_EN
      tp_q      <= tp_d;
`endif
    end
  end

  assign rd_addr     = rd_addr_q;
  assign level       = level_q;
  assign pwm_thresh  = pwm_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_video_line_sequencer.sv
// Bench for video_line_sequencer on a shrunken raster, checked every clock against an arithmetic raster model.
// BRAM is modelled as a registered-read array filled with random rows.
module tb_video_line_sequencer;

  localparam int PW = 24;
  localparam int PD = 3;
  localparam int HT = 96;
  localparam int HS = 7;
  localparam int HB = 9;
  localparam int VT = 40;
  localparam int VS = 3;
  localparam int VB = 4;
  localparam int AL = 30;
  localparam int LS = 0;
  localparam int LB = 4;
  localparam int LW = 9;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;

`ifdef VIDEO_TESTPAT_EN
  localparam bit HAS_TP = 1'b1;
`else
  localparam bit HAS_TP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          tp_drv;
  logic [9:0]    rd_addr;
  logic [PW-1:0] rd_data;
  logic [1:0]    level;
  logic [7:0]    pwm_thresh;
  logic          line_start;
  logic          frame_start;

  logic [PW-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int mh = 0;
  int mv = 0;
  int mtp = 0;
  int maddr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  video_line_sequencer #(
    .PIX_W(PW), .PIX_DIV(PD), .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .ACT_LINES(AL),
    .LVL_SYNC(LS), .LVL_BLACK(LB), .LVL_WHITE(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
`ifdef VIDEO_TESTPAT_EN
    .test_pat(tp_drv),
`endif
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .level(level),
    .pwm_thresh(pwm_thresh),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  // Expected level for raster position (h,v) straight from the line-class rules.
  function automatic int ref_level(int h, int v, int tp);
    int p;
    int r;
    if (v < VS) return (h < HT - HS) ? 0 : 1;
    if (h < HS) return 0;
    if (v >= VA && v < VA + AL && h >= HA && h < HA + PW * PD) begin
      p = (h - HA) / PD;
      r = v - VA;
      if (tp != 0) return ((((p / 8) + (r / 8)) % 2) == 1) ? 2 : 1;
      return mem[r][p] ? 2 : 1;
    end
    return 1;
  endfunction

  function automatic int pwm_of(int l);
    if (l == 0) return LS;
    if (l == 2) return LW;
    return LB;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic tp);
    int el;
    int els;
    int efs;
    rst_n  = r;
    en     = e;
    tp_drv = tp;
    el  = 1;
    els = 0;
    efs = 0;
    if (!r) begin
      maddr = 0;
      mh    = 0;
      mv    = 0;
      mtp   = 0;
    end else begin
      if (e) begin
        el  = ref_level(mh, mv, HAS_TP ? mtp : 0);
        els = (mh == 0) ? 1 : 0;
        efs = (mh == 0 && mv == 0) ? 1 : 0;
        if (mh == 0 && mv >= VA && mv < VA + AL) maddr = mv - VA;
      end
      if (mh == 0) mtp = tp ? 1 : 0;
      if (!e) begin
        mh = 0;
        mv = 0;
      end else begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), el);
    chk("pwm_thresh", 32'(pwm_thresh), pwm_of(el));
    chk("line_start", 32'(line_start), els);
    chk("frame_start", 32'(frame_start), efs);
    chk("rd_addr", 32'(rd_addr), maddr);
  endtask

  initial begin
    logic en_cur;
    logic tp_cur;
    logic rst_cur;
    rst_n  = 1'b0;
    en     = 1'b1;
    tp_drv = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = PW'($urandom);

    // Reset held with en high: BLACK, LVL_BLACK, row address 0, no pulses.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // One full frame plus a line: vsync broad pulses, blank lines, every active row, wrap.
    for (int i = 0; i < VT * HT + HT; i++) step(1'b1, 1'b1, 1'b0);

    // Drop enable partway through an active line, then restart from the top.
    for (int i = 0; i < VT * HT; i++) begin
      if (mv == VA + 3 && mh == 50) break;
      step(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * HT; i++) step(1'b1, 1'b1, 1'b0);

    // A frame with the test-pattern request raised.
    for (int i = 0; i < VT * HT; i++) step(1'b1, 1'b1, 1'b1);

    // Random enable gaps, occasional mid-frame resets, and test_pat toggles.
    en_cur = 1'b1;
    tp_cur = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      rst_cur = ($urandom_range(0, 2999) != 0);
      if (en_cur && $urandom_range(0, 399) == 0) en_cur = 1'b0;
      else if (!en_cur && $urandom_range(0, 9) == 0) en_cur = 1'b1;
      if ($urandom_range(0, 49) == 0) tp_cur = 1'($urandom_range(0, 1));
      step(rst_cur, en_cur, tp_cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
